cv32e40x_xif_result_queue: RTL and testbench
============================================

Name: cv32e40x_xif_result_queue

Overview:
Coprocessor-side driver of the eXtension result interface. It is the responder end of the channel that the core's write-back stage consumes. Completed results from coprocessor execution units are buffered in program order and presented to the core via result_valid/result_ready. Results of instructions killed through the commit interface are discarded and never presented.

Parameters:
DEPTH, 2, number of buffered result entries (>=1).
X_ID_WIDTH, 4, width of instruction id.
X_RFW_WIDTH, 32, width of result data.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
push_valid_i  in  1  execution unit has a completed result
push_ready_o  out  1  queue can accept a result
push_id_i  in  X_ID_WIDTH  instruction id of pushed result
push_data_i  in  X_RFW_WIDTH  result data
push_rd_i  in  5  destination register
push_we_i  in  1  register write enable
push_exc_i  in  1  synchronous exception flag
push_exccode_i  in  6  exception code
commit_valid_i  in  1  commit transaction valid
commit_id_i  in  X_ID_WIDTH  id being committed or killed
commit_kill_i  in  1  1 = kill id, 0 = commit id
result_valid_o  out  1  result presented to core
result_ready_i  in  1  core accepts result
result_id_o  out  X_ID_WIDTH  head id
result_data_o  out  X_RFW_WIDTH  head data
result_rd_o  out  5  head rd
result_we_o  out  1  head we
result_exc_o  out  1  head exc
result_exccode_o  out  6  head exccode
occupancy_o  out  $clog2(DEPTH+1)  number of stored entries, killed entries included

Behaviour:
- Storage is a circular FIFO.
  - Read and write pointers wrap modulo DEPTH.
  - Each entry holds {id, data, rd, we, exc, exccode, killed}.
- Reset state:
  - Pointers and occupancy are 0.
  - All entry valid bits, the kill vector and all result_* outputs are 0.
- Push path:
  - push_ready_o = (occupancy != DEPTH). It is registered-state only, with no combinational path from result_ready_i.
  - Push fires when push_valid_i && push_ready_o.
  - A pushed entry is visible at the head no earlier than the next cycle (minimum latency 1, no bypass).
- Kill tracking:
  - kill_vec is a 2^X_ID_WIDTH-bit vector.
  - commit_valid_i && commit_kill_i sets kill_vec[commit_id_i] and sets the killed bit of every stored entry whose id equals commit_id_i.
  - commit_valid_i && !commit_kill_i clears kill_vec[commit_id_i].
  - A push whose id has kill_vec set, or matches a kill in the same cycle, is stored with killed=1. That push clears kill_vec[id].
  - A kill and a commit can never target the same id in the same cycle. This is an assertion.
- Head handling:
  - If the head is valid and killed, it is dropped (read pointer advances) without asserting result_valid_o. One entry is dropped per cycle.
  - result_valid_o = head valid && !head killed.
  - A pop fires when result_valid_o && result_ready_i; the read pointer advances.
  - While result_valid_o=1 and result_ready_i=0, all result_* outputs are held stable (XIF rule).
  - A kill for the presented head id after result_valid_o has risen is a protocol violation. This is an assertion; the core never kills an instruction whose result it is waiting for.
- Simultaneous push and pop/drop: occupancy is unchanged; both pointers advance.
- Full queue: push_ready_o=0. A pop in cycle n raises push_ready_o in cycle n+1.
- Empty queue: result_valid_o=0 and result_* outputs are 0.
- When result_valid_o=0, result_* outputs are driven to 0.
- Assertions:
  - No push while full.
  - occupancy_o <= DEPTH.
  - Stability of result_* under backpressure.
  - Head id order matches push order.

Test Plan:
- Reset release, then push id=3, data=0xDEADBEEF, rd=5, we=1 with result_ready_i=1 -> result_valid_o=1 one cycle later with those values; occupancy returns 0 after the pop.
- Push ids 1 and 2 with DEPTH=2 and result_ready_i=0 -> push_ready_o=0, occupancy_o=2. Raise ready -> id1 then id2 in consecutive cycles; push_ready_o=1 the cycle after the first pop.
- Hold result_ready_i=0 for 5 cycles with the head valid -> all result_* outputs constant; a new push of id 4 does not disturb the head.
- Kill id 6 before its push, then push id 6 and then id 7 -> id 6 is never presented; id 7 appears with result_valid_o one cycle after its drop; kill_vec[6] is cleared.
- Push id 2 with exc=1, exccode=0x02, we=0 -> presented with result_exc_o=1, result_exccode_o=2.
- Assert rst_n low with 2 entries stored -> result_valid_o=0, occupancy_o=0, push_ready_o=1 immediately and asynchronously; no stale result after release.

Source files
------------

// File: rtl/cv32e40x_xif_result_queue.sv
// Coprocessor-side eXtension result channel driver: in-order result FIFO that
// silently discards results of instructions killed through the commit interface.
module cv32e40x_xif_result_queue #(
  parameter int DEPTH       = 2,
  parameter int X_ID_WIDTH  = 4,
  parameter int X_RFW_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_valid_i,
  output logic                         push_ready_o,
  input  logic [X_ID_WIDTH-1:0]        push_id_i,
  input  logic [X_RFW_WIDTH-1:0]       push_data_i,
  input  logic [4:0]                   push_rd_i,
  input  logic                         push_we_i,
  input  logic                         push_exc_i,
  input  logic [5:0]                   push_exccode_i,
  input  logic                         commit_valid_i,
  input  logic [X_ID_WIDTH-1:0]        commit_id_i,
  input  logic                         commit_kill_i,
  output logic                         result_valid_o,
  input  logic                         result_ready_i,
  output logic [X_ID_WIDTH-1:0]        result_id_o,
  output logic [X_RFW_WIDTH-1:0]       result_data_o,
  output logic [4:0]                   result_rd_o,
  output logic                         result_we_o,
  output logic                         result_exc_o,
  output logic [5:0]                   result_exccode_o,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy_o
);

  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W   = $clog2(DEPTH+1);
  localparam int NUM_IDS = 1 << X_ID_WIDTH;

  logic [PTR_W-1:0]       rptr_reg, wptr_reg;
  logic [OCC_W-1:0]       occ_reg;
  logic [NUM_IDS-1:0]     kill_vec_reg;
  logic [DEPTH-1:0]       valid_reg, killed_reg;
  logic [X_ID_WIDTH-1:0]  id_reg      [DEPTH];
  logic [X_RFW_WIDTH-1:0] data_reg    [DEPTH];
  logic [4:0]             rd_reg      [DEPTH];
  logic                   we_reg      [DEPTH];
  logic                   exc_reg     [DEPTH];
  logic [5:0]             exccode_reg [DEPTH];

  logic head_valid, head_killed, push_fire, drop, pop, advance, kill_now, push_killed;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign head_valid   = valid_reg[rptr_reg];
  assign head_killed  = killed_reg[rptr_reg];
  assign push_ready_o = (occ_reg != OCC_W'(DEPTH));
  assign push_fire    = push_valid_i && push_ready_o;
  assign kill_now     = commit_valid_i && commit_kill_i;
  // A kill arriving in the same cycle as the push must still mark the new entry
  assign push_killed  = kill_vec_reg[push_id_i] || (kill_now && (commit_id_i == push_id_i));
  assign drop         = head_valid && head_killed;
  assign pop          = result_valid_o && result_ready_i;
  assign advance      = drop || pop;
  assign occupancy_o  = occ_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg  <= '0;
      killed_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        id_reg[i]      <= '0;
        data_reg[i]    <= '0;
        rd_reg[i]      <= '0;
        we_reg[i]      <= 1'b0;
        exc_reg[i]     <= 1'b0;
        exccode_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        // Write slot is never the slot being vacated: that would need full and empty at once
        if (push_fire && (wptr_reg == PTR_W'(i))) begin
          valid_reg[i]   <= 1'b1;
          killed_reg[i]  <= push_killed;
          id_reg[i]      <= push_id_i;
          data_reg[i]    <= push_data_i;
          rd_reg[i]      <= push_rd_i;
          we_reg[i]      <= push_we_i;
          exc_reg[i]     <= push_exc_i;
          exccode_reg[i] <= push_exccode_i;
        end else begin
          if (advance && (rptr_reg == PTR_W'(i)))
            valid_reg[i] <= 1'b0;
          if (kill_now && valid_reg[i] && (id_reg[i] == commit_id_i))
            killed_reg[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kill_vec_reg <= '0;
    end else begin
      if (kill_now)
        kill_vec_reg[commit_id_i] <= 1'b1;
      else if (commit_valid_i)
        kill_vec_reg[commit_id_i] <= 1'b0;
      // The push consumes the pending kill, overriding a same-cycle set
      if (push_fire)
        kill_vec_reg[push_id_i] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_reg <= '0;
      wptr_reg <= '0;
      occ_reg  <= '0;
    end else begin
      if (push_fire) wptr_reg <= ptr_inc(wptr_reg);
      if (advance)   rptr_reg <= ptr_inc(rptr_reg);
      if (push_fire && !advance)      occ_reg <= occ_reg + OCC_W'(1);
      else if (!push_fire && advance) occ_reg <= occ_reg - OCC_W'(1);
    end
  end

  always_comb begin
    result_valid_o   = head_valid && !head_killed;
    result_id_o      = '0;
    result_data_o    = '0;
    result_rd_o      = '0;
    result_we_o      = 1'b0;
    result_exc_o     = 1'b0;
    result_exccode_o = '0;
    if (result_valid_o) begin
      result_id_o      = id_reg[rptr_reg];
      result_data_o    = data_reg[rptr_reg];
      result_rd_o      = rd_reg[rptr_reg];
      result_we_o      = we_reg[rptr_reg];
      result_exc_o     = exc_reg[rptr_reg];
      result_exccode_o = exccode_reg[rptr_reg];
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    push_fire |-> (occ_reg < OCC_W'(DEPTH)));
  a_occ_bound: assert property (@(posedge clk) disable iff (!rst_n)
    occ_reg <= OCC_W'(DEPTH));
  a_no_kill_presented: assert property (@(posedge clk) disable iff (!rst_n)
    !(kill_now && result_valid_o && (commit_id_i == result_id_o)));
  a_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (result_valid_o && !result_ready_i) |=> (result_valid_o && $stable(result_id_o) &&
      $stable(result_data_o) && $stable(result_rd_o) && $stable(result_we_o) &&
      $stable(result_exc_o) && $stable(result_exccode_o)));

endmodule

// File: tb/tb_cv32e40x_xif_result_queue.sv
// Directed bench: queue-based reference model checked every cycle, plus literal
// expectations from the test plan.
module tb_cv32e40x_xif_result_queue;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        push_valid = 1'b0, push_ready;
  logic [3:0]  push_id = '0;
  logic [31:0] push_data = '0;
  logic [4:0]  push_rd = '0;
  logic        push_we = 1'b0, push_exc = 1'b0;
  logic [5:0]  push_exccode = '0;
  logic        commit_valid = 1'b0, commit_kill = 1'b0;
  logic [3:0]  commit_id = '0;
  logic        result_valid, result_ready = 1'b0;
  logic [3:0]  result_id;
  logic [31:0] result_data;
  logic [4:0]  result_rd;
  logic        result_we, result_exc;
  logic [5:0]  result_exccode;
  logic [1:0]  occupancy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cv32e40x_xif_result_queue #(.DEPTH(DEPTH), .X_ID_WIDTH(4), .X_RFW_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .push_valid_i(push_valid), .push_ready_o(push_ready), .push_id_i(push_id),
    .push_data_i(push_data), .push_rd_i(push_rd), .push_we_i(push_we),
    .push_exc_i(push_exc), .push_exccode_i(push_exccode),
    .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
    .result_valid_o(result_valid), .result_ready_i(result_ready), .result_id_o(result_id),
    .result_data_o(result_data), .result_rd_o(result_rd), .result_we_o(result_we),
    .result_exc_o(result_exc), .result_exccode_o(result_exccode), .occupancy_o(occupancy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: program-order list of stored results plus pending-kill set
  typedef struct {
    logic [3:0] id; logic [31:0] data; logic [4:0] rd;
    logic we; logic exc; logic [5:0] code; logic killed;
  } ent_t;
  ent_t q[$];
  bit   kv[16];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      for (int i = 0; i < 16; i++) kv[i] = 1'b0;
    end else begin
      bit   leave, fire;
      ent_t e;
      leave = (q.size() > 0) && (q[0].killed || result_ready);
      fire  = push_valid && (q.size() < DEPTH);
      if (commit_valid && commit_kill)
        foreach (q[i]) if (q[i].id == commit_id) q[i].killed = 1'b1;
      e = '{push_id, push_data, push_rd, push_we, push_exc, push_exccode,
            kv[push_id] || (commit_valid && commit_kill && commit_id == push_id)};
      if (commit_valid) kv[commit_id] = commit_kill;
      if (fire) kv[push_id] = 1'b0;
      if (leave) void'(q.pop_front());
      if (fire) q.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      bit ev;
      ev = (q.size() > 0) && !q[0].killed;
      chk("m_valid", result_valid, ev);
      chk("m_id", result_id, ev ? q[0].id : 4'd0);
      chk("m_data", result_data, ev ? q[0].data : 32'd0);
      chk("m_rd", result_rd, ev ? q[0].rd : 5'd0);
      chk("m_we_exc", {result_we, result_exc}, ev ? {q[0].we, q[0].exc} : 2'b00);
      chk("m_exccode", result_exccode, ev ? q[0].code : 6'd0);
      chk("m_occ", occupancy, q.size());
      chk("m_push_ready", push_ready, q.size() != DEPTH);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] id, input logic [31:0] d, input logic [4:0] rd,
                      input logic we, input logic exc, input logic [5:0] code);
    push_valid = 1'b1; push_id = id; push_data = d; push_rd = rd;
    push_we = we; push_exc = exc; push_exccode = code;
    step();
    push_valid = 1'b0;
  endtask

  task automatic commit(input logic [3:0] id, input logic kill);
    commit_valid = 1'b1; commit_id = id; commit_kill = kill;
    step();
    commit_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_valid", result_valid, 1'b0);
    chk("rst_occ", occupancy, 2'd0);
    chk("rst_push_ready", push_ready, 1'b1);

    // Single result, consumed immediately
    result_ready = 1'b1;
    push(4'd3, 32'hDEADBEEF, 5'd5, 1'b1, 1'b0, 6'd0);
    chk("t1_valid", result_valid, 1'b1);
    chk("t1_id", result_id, 4'd3);
    chk("t1_data", result_data, 32'hDEADBEEF);
    chk("t1_rd_we", {result_rd, result_we}, {5'd5, 1'b1});
    step();
    chk("t1_occ_after", occupancy, 2'd0);
    chk("t1_valid_after", result_valid, 1'b0);

    // Fill to full under backpressure, then drain
    result_ready = 1'b0;
    push(4'd1, 32'h11, 5'd1, 1'b1, 1'b0, 6'd0);
    push(4'd2, 32'h22, 5'd2, 1'b1, 1'b0, 6'd0);
    chk("t2_full_ready", push_ready, 1'b0);
    chk("t2_full_occ", occupancy, 2'd2);
    chk("t2_head1", result_id, 4'd1);
    result_ready = 1'b1;
    step();
    chk("t2_head2", result_id, 4'd2);
    chk("t2_ready_back", push_ready, 1'b1);
    step();
    chk("t2_empty", occupancy, 2'd0);

    // Hold head for 5 cycles; a push of id 4 must not disturb it
    result_ready = 1'b0;
    push(4'd8, 32'hCAFE0008, 5'd8, 1'b1, 1'b0, 6'd0);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) push(4'd4, 32'h44, 5'd4, 1'b1, 1'b0, 6'd0);
      else step();
      chk("t3_hold_id", result_id, 4'd8);
      chk("t3_hold_data", result_data, 32'hCAFE0008);
      chk("t3_hold_valid", result_valid, 1'b1);
    end
    chk("t3_occ", occupancy, 2'd2);
    result_ready = 1'b1;
    step();
    chk("t3_next", result_id, 4'd4);
    step();

    // Kill before push: id 6 dropped, id 7 presented, id 6 usable again afterwards
    commit(4'd6, 1'b1);
    push(4'd6, 32'h66, 5'd6, 1'b1, 1'b0, 6'd0);
    chk("t4_killed_hidden", result_valid, 1'b0);
    chk("t4_killed_occ", occupancy, 2'd1);
    push(4'd7, 32'h77, 5'd7, 1'b1, 1'b0, 6'd0);
    chk("t4_id7_valid", result_valid, 1'b1);
    chk("t4_id7", result_id, 4'd7);
    step();
    push(4'd6, 32'h6666, 5'd6, 1'b1, 1'b0, 6'd0);
    chk("t4_id6_again", {result_valid, result_id}, {1'b1, 4'd6});
    step();

    // Exception result
    push(4'd2, 32'h0, 5'd0, 1'b0, 1'b1, 6'h02);
    chk("t5_exc", {result_valid, result_exc, result_exccode, result_we}, {1'b1, 1'b1, 6'd2, 1'b0});
    step();

    // Kill coinciding with the push of the same id
    commit_valid = 1'b1; commit_kill = 1'b1; commit_id = 4'd9;
    push(4'd9, 32'h99, 5'd9, 1'b1, 1'b0, 6'd0);
    commit_valid = 1'b0;
    chk("t6_same_cycle_kill", {result_valid, occupancy}, {1'b0, 2'd1});
    step();

    // Kill a stored non-head entry
    result_ready = 1'b0;
    push(4'd10, 32'hA, 5'd10, 1'b1, 1'b0, 6'd0);
    push(4'd11, 32'hB, 5'd11, 1'b1, 1'b0, 6'd0);
    commit(4'd11, 1'b1);
    chk("t7_head10", {result_valid, result_id}, {1'b1, 4'd10});
    result_ready = 1'b1;
    step();
    chk("t7_killed_tail", {result_valid, occupancy}, {1'b0, 2'd1});
    step();
    chk("t7_drained", occupancy, 2'd0);

    // A commit clears a pending kill
    commit(4'd12, 1'b1);
    commit(4'd12, 1'b0);
    push(4'd12, 32'hC, 5'd12, 1'b1, 1'b0, 6'd0);
    chk("t8_commit_clears", {result_valid, result_id}, {1'b1, 4'd12});
    step();

    // Asynchronous reset with two stored entries
    result_ready = 1'b0;
    push(4'd1, 32'h1, 5'd1, 1'b1, 1'b0, 6'd0);
    push(4'd2, 32'h2, 5'd2, 1'b1, 1'b0, 6'd0);
    chk("t9_pre_occ", occupancy, 2'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t9_async_valid", result_valid, 1'b0);
    chk("t9_async_occ", occupancy, 2'd0);
    chk("t9_async_ready", push_ready, 1'b1);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("t9_post_valid", {result_valid, result_id}, {1'b0, 4'd0});
    chk("t9_post_occ", occupancy, 2'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
